trap_filter_v2: RTL and testbench
=================================

Name: trap_filter_v2

Overview:
- Parametrised, run-time configurable trapezoidal pulse shaper.
- Implements d[n]=v[n]-v[n-k]-v[n-l]+v[n-k-l]; p[n]=p[n-1]+d[n]; r[n]=p[n]+M*d[n]; s[n]=s[n-1]+r[n]; out = sat(s[n] >>> shift).
- Sits between the ADC sample stream and the peak/energy logic.
- Adds to the current filter: a valid-qualified sample stream, programmable k/l/M/shift with legality check, and a saturating output with flag.

Parameters:
- DATA_W, 16, input/output sample width (signed).
- MAX_DEPTH, 64, maximum k+l; sets delay-line length.
- M_W, 8, width of unsigned M multiplier.
- ACC_W, 40, width of internal p/r/s accumulators (signed); must be >= DATA_W+M_W+2*clog2(MAX_DEPTH)+4.
- K_DEF, 2; L_DEF, 4; M_DEF, 0; SHIFT_DEF, 4: reset values of the configuration registers.

Ports:
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-low.
- in_valid, in, 1, in_data holds a new sample this cycle.
- in_data, in, DATA_W, signed input sample.
- cfg_we, in, 1, one-cycle strobe loading cfg_k/cfg_l/cfg_m/cfg_shift.
- cfg_k, in, clog2(MAX_DEPTH+1), rise length k.
- cfg_l, in, clog2(MAX_DEPTH+1), l (flat top = l-k).
- cfg_m, in, M_W, unsigned pole-zero multiplier M.
- cfg_shift, in, 5, arithmetic right shift applied to s.
- cfg_err, out, 1, sticky: last cfg_we was rejected.
- out_valid, out, 1, out_data valid this cycle.
- out_data, out, DATA_W, signed shaped output.
- out_sat, out, 1, out_data was clamped (qualified by out_valid).

Behaviour:
- Reset (reset==0 at posedge):
  - Delay line, d, p, M*d, r and s are cleared to 0.
  - All stage valids are cleared.
  - out_valid=0, out_data=0, out_sat=0, cfg_err=0.
  - k/l/M/shift are loaded from the *_DEF parameters.
  - Reset overrides every other input, including mid-pulse.
- Delay line:
  - Shift register of MAX_DEPTH+1 entries that advances only on in_valid.
  - Taps are selected by the registered k, l and k+l (run-time mux).
- Pipeline: five stages, each advancing only when its input valid is set; there is no backpressure.
  - S1: d <= in_data - tap[k] - tap[l] + tap[k+l], using the taps before the shift. Width DATA_W+2.
  - S2: p <= p + d (ACC_W); md <= d * M (signed x unsigned, sign-extended to ACC_W).
  - S3: r <= p + md, where p is the value updated in S2.
  - S4: s <= s + r.
  - S5: t = s >>> shift, then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
    - out_data <= clamped value.
    - out_sat <= (t was out of range).
    - out_valid <= 1.
- Latency and throughput:
  - out_valid rises exactly 5 clk after the in_valid cycle of the same sample.
  - One output per accepted input, in order.
  - in_valid may be continuous or sparse; gaps do not alter results.
  - out_valid=0 on cycles with no sample leaving S5; out_data then holds its last value.
- Accumulators wrap modulo 2^ACC_W (two's complement). No saturation occurs inside the pipeline.
- Configuration:
  - cfg_we is accepted iff k>=1, l>=k and k+l<=MAX_DEPTH. On accept:
    - The new k/l/M/shift are registered.
    - cfg_err is cleared.
    - The delay line, d, p, md, r, s and all stage valids are cleared on the same edge; in-flight samples are dropped.
  - A rejected cfg_we:
    - sets cfg_err=1;
    - leaves configuration and datapath state untouched.
  - cfg_we together with in_valid: the configuration action takes priority and that input sample is discarded, whether the configuration is accepted or rejected.
  - shift values >= ACC_W are treated as ACC_W-1.

Test Plan:
- Impulse with k=2, l=4, M=0, shift=0: one in_data=100 followed by zeros, in_valid continuous -> out_data = 100,200,200,200,100,0,0… with first out_valid 5 cycles after the impulse, out_sat=0.
- M path with k=1, l=2, M=2, shift=0: impulse 10 -> out_data = 30,10,-20,0,0…
- Saturation with k=2, l=4, M=0, shift=0: impulse 30000 -> out_data = 30000, then 32767 for three samples (out_sat=1 on those only), then 30000, 0. Repeat with impulse -30000 -> clamp to -32768.
- Sparse input: rerun the impulse-100 case with in_valid asserted every 3rd cycle -> identical out_data sequence, one out_valid per in_valid, each 5 cycles after its input.
- Illegal config:
  - cfg_we with k=3, l=2, then k=40, l=40 (MAX_DEPTH=64) -> cfg_err=1 after each, config unchanged; the impulse-100 test still yields 100,200,200,200,100.
  - A legal cfg_we -> cfg_err=0 and history cleared.
  - cfg_we in the same cycle as in_valid -> that sample produces no out_valid.
- Reset mid-pulse: drive reset=0 for one cycle during the impulse-100 response -> next cycle out_valid=0, out_data=0, cfg_err=0, config back to defaults. Subsequent impulse 100 with defaults (shift=4) -> 6,12,12,12,6,0.

Source files
------------

// File: rtl/trap_filter_v2.sv
// Trapezoidal pulse shaper: a delay-line difference followed by two accumulators and a
// pole-zero term. It has a valid-qualified sample stream and run-time k/l/M/shift configuration.
module trap_filter_v2 #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_DEPTH = 64,
    parameter int unsigned M_W       = 8,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned K_DEF     = 2,
    parameter int unsigned L_DEF     = 4,
    parameter int unsigned M_DEF     = 0,
    parameter int unsigned SHIFT_DEF = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic signed [DATA_W-1:0]             in_data,
    input  logic                                 cfg_we,
    input  logic        [$clog2(MAX_DEPTH+1)-1:0] cfg_k,
    input  logic        [$clog2(MAX_DEPTH+1)-1:0] cfg_l,
    input  logic        [M_W-1:0]                cfg_m,
    input  logic        [4:0]                    cfg_shift,
    output logic                                 cfg_err,
    output logic                                 out_valid,
    output logic signed [DATA_W-1:0]             out_data,
    output logic                                 out_sat
);

    localparam int unsigned CW = $clog2(MAX_DEPTH + 1);
    localparam int unsigned DW = DATA_W + 2;

    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W - DATA_W + 1){1'b0}},
                                                  {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W - DATA_W + 1){1'b1}},
                                                  {(DATA_W - 1){1'b0}}};

    // ------------------------------------------------------------------
    // Configuration
    // ------------------------------------------------------------------
    logic [CW-1:0]  k_q, l_q, kl_q;
    logic [M_W-1:0] m_q;
    logic [4:0]     shift_q;
    logic           cfg_err_q;

    logic [CW:0]    cfg_sum;
    logic           cfg_legal;
    logic           flush;
    logic           sample_en;

    always_comb begin
        cfg_sum   = {1'b0, cfg_k} + {1'b0, cfg_l};
        cfg_legal = (cfg_k != '0) && (cfg_l >= cfg_k) && (cfg_sum <= (CW + 1)'(MAX_DEPTH));
        flush     = cfg_we && cfg_legal;
        // Configuration writes take priority; a coincident sample is dropped.
        sample_en = in_valid && !cfg_we;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            k_q       <= CW'(K_DEF);
            l_q       <= CW'(L_DEF);
            kl_q      <= CW'(K_DEF + L_DEF);
            m_q       <= M_W'(M_DEF);
            shift_q   <= 5'(SHIFT_DEF);
            cfg_err_q <= 1'b0;
        end else if (cfg_we) begin
            if (cfg_legal) begin
                k_q       <= cfg_k;
                l_q       <= cfg_l;
                kl_q      <= cfg_sum[CW-1:0];
                m_q       <= cfg_m;
                shift_q   <= cfg_shift;
                cfg_err_q <= 1'b0;
            end else begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    assign cfg_err = cfg_err_q;

    // ------------------------------------------------------------------
    // Delay line: hist_q[j] holds v[n-1-j], so tap(k) = v[n-k] = hist_q[k-1]
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] hist_q [MAX_DEPTH+1];
    logic signed [DATA_W-1:0] tap_k, tap_l, tap_kl;

    always_comb begin
        tap_k  = hist_q[k_q - 1'b1];
        tap_l  = hist_q[l_q - 1'b1];
        tap_kl = hist_q[kl_q - 1'b1];
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            for (int i = 0; i <= int'(MAX_DEPTH); i++) begin
                hist_q[i] <= '0;
            end
        end else if (sample_en) begin
            hist_q[0] <= in_data;
            for (int i = 1; i <= int'(MAX_DEPTH); i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Five-stage datapath
    // ------------------------------------------------------------------
    logic signed [DW-1:0]    d_q, d_d;
    logic signed [ACC_W-1:0] p_q, p_d;
    logic signed [ACC_W-1:0] md_q, md_d;
    logic signed [ACC_W-1:0] r_q, r_d;
    logic signed [ACC_W-1:0] s_q, s_d;
    logic                    v1_q, v2_q, v3_q, v4_q;

    logic signed [ACC_W-1:0] d_ext, m_ext;
    logic signed [ACC_W-1:0] t_val;
    int unsigned             sh_amt;

    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;
    logic                     out_valid_q;

    always_comb begin
        d_d   = DW'(in_data) - DW'(tap_k) - DW'(tap_l) + DW'(tap_kl);

        d_ext = ACC_W'(d_q);
        m_ext = ACC_W'(m_q);
        p_d   = p_q + d_ext;
        md_d  = d_ext * m_ext;

        r_d   = p_q + md_q;
        s_d   = s_q + r_q;
    end

    always_comb begin
        sh_amt = 32'(shift_q);
        if (sh_amt >= ACC_W) begin
            sh_amt = ACC_W - 1;
        end
        t_val = s_q >>> sh_amt;
        if (t_val > SAT_HI) begin
            out_data_d = SAT_HI[DATA_W-1:0];
            out_sat_d  = 1'b1;
        end else if (t_val < SAT_LO) begin
            out_data_d = SAT_LO[DATA_W-1:0];
            out_sat_d  = 1'b1;
        end else begin
            out_data_d = t_val[DATA_W-1:0];
            out_sat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            d_q  <= '0;
            p_q  <= '0;
            md_q <= '0;
            r_q  <= '0;
            s_q  <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            v4_q <= 1'b0;
        end else begin
            v1_q <= sample_en;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            if (sample_en) begin
                d_q <= d_d;
            end
            if (v1_q) begin
                p_q  <= p_d;
                md_q <= md_d;
            end
            if (v2_q) begin
                r_q <= r_d;
            end
            if (v3_q) begin
                s_q <= s_d;
            end
        end
    end

    // Output data/sat hold their last value across a flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= v4_q && !flush;
            if (v4_q && !flush) begin
                out_data_q <= out_data_d;
                out_sat_q  <= out_sat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_trap_filter_v2.sv
// Scoreboard bench for trap_filter_v2: a behavioural model of the shaping equations pushes
// expected outputs at drive time; a negedge monitor pops and compares them.
module tb_trap_filter_v2;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MAX_DEPTH = 64;
    localparam int unsigned M_W       = 8;
    localparam int unsigned ACC_W     = 40;
    localparam int unsigned CW        = $clog2(MAX_DEPTH + 1);

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     cfg_we;
    logic [CW-1:0]            cfg_k, cfg_l;
    logic [M_W-1:0]           cfg_m;
    logic [4:0]               cfg_shift;
    logic                     cfg_err;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;

    always #5 clk = ~clk;

    trap_filter_v2 #(
        .DATA_W   (DATA_W),
        .MAX_DEPTH(MAX_DEPTH),
        .M_W      (M_W),
        .ACC_W    (ACC_W),
        .K_DEF    (2),
        .L_DEF    (4),
        .M_DEF    (0),
        .SHIFT_DEF(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .cfg_we   (cfg_we),
        .cfg_k    (cfg_k),
        .cfg_l    (cfg_l),
        .cfg_m    (cfg_m),
        .cfg_shift(cfg_shift),
        .cfg_err  (cfg_err),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard
    longint exp_q [$];
    bit     sat_q [$];
    int     cyc_q [$];

    // Reference model state
    longint hist_m [1:MAX_DEPTH];
    longint mp, ms;
    int     mk, ml, mm, msh;

    function automatic longint wrap(input longint x);
        return (x <<< (64 - ACC_W)) >>> (64 - ACC_W);
    endfunction

    task automatic model_clear();
        for (int j = 1; j <= int'(MAX_DEPTH); j++) hist_m[j] = 0;
        mp = 0;
        ms = 0;
    endtask

    task automatic model_reset();
        mk = 2; ml = 4; mm = 0; msh = 4;
        model_clear();
    endtask

    task automatic model_push(input longint v);
        longint d, r, t;
        int     sh;
        bit     s;
        d = v - hist_m[mk] - hist_m[ml] + hist_m[mk + ml];
        for (int j = int'(MAX_DEPTH); j >= 2; j--) hist_m[j] = hist_m[j-1];
        hist_m[1] = v;
        mp = wrap(mp + d);
        r  = wrap(mp + wrap(d * mm));
        ms = wrap(ms + r);
        sh = (msh >= int'(ACC_W)) ? int'(ACC_W) - 1 : msh;
        t  = ms >>> sh;
        s  = 1'b0;
        if (t > 32767) begin t = 32767; s = 1'b1; end
        else if (t < -32768) begin t = -32768; s = 1'b1; end
        exp_q.push_back(t);
        sat_q.push_back(s);
        cyc_q.push_back(cyc);
    endtask

    // Drop expectations for samples still in flight when a flush lands at the next edge.
    task automatic prune();
        while (cyc_q.size() > 0 && cyc_q[$] >= cyc - 4) begin
            void'(exp_q.pop_back());
            void'(sat_q.pop_back());
            void'(cyc_q.pop_back());
        end
    endtask

    task automatic step(input bit iv, input int data, input bit we,
                        input int k, input int l, input int m, input int sh);
        in_valid  = iv;
        in_data   = DATA_W'(data);
        cfg_we    = we;
        cfg_k     = CW'(k);
        cfg_l     = CW'(l);
        cfg_m     = M_W'(m);
        cfg_shift = 5'(sh);
        if (we) begin
            if (k >= 1 && l >= k && k + l <= int'(MAX_DEPTH)) begin
                mk = k; ml = l; mm = m; msh = sh;
                prune();
                model_clear();
            end
        end else if (iv) begin
            model_push(longint'(data));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic send(input int data);
        step(1'b1, data, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int k, input int l, input int m, input int sh);
        step(1'b0, 0, 1'b1, k, l, m, sh);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic impulse(input int amp, input int gap);
        send(amp);
        for (int i = 0; i < 10; i++) begin
            idle(gap - 1);
            send(0);
        end
        idle(8);
    endtask

    // Monitor
    longint mon_e;
    bit     mon_s;
    int     mon_c;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_s = sat_q.pop_front();
                mon_c = cyc_q.pop_front();
                check_val("out_data", longint'(out_data), mon_e);
                check_val("out_sat", longint'(out_sat), longint'(mon_s));
                check_val("latency", longint'(cyc - mon_c), 5);
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_we    = 1'b0;
        cfg_k     = '0;
        cfg_l     = '0;
        cfg_m     = '0;
        cfg_shift = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", longint'(out_valid), 0);
        check_val("rst_out_data", longint'(out_data), 0);
        check_val("rst_out_sat", longint'(out_sat), 0);
        check_val("rst_cfg_err", longint'(cfg_err), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic impulse, then M path, then saturation both signs
        cfg(2, 4, 0, 0);
        check_val("cfg_ok_err", longint'(cfg_err), 0);
        impulse(100, 1);
        cfg(1, 2, 2, 0);
        impulse(10, 1);
        cfg(2, 4, 0, 0);
        impulse(30000, 1);
        impulse(-30000, 1);

        // Sparse input
        impulse(100, 3);

        // Illegal configurations leave the filter as it was
        cfg(3, 2, 0, 0);
        check_val("illegal_k_gt_l", longint'(cfg_err), 1);
        cfg(40, 40, 0, 0);
        check_val("illegal_sum", longint'(cfg_err), 1);
        impulse(100, 1);

        // Legal config clears error and history mid-pulse
        send(100);
        send(0);
        cfg(2, 4, 0, 0);
        check_val("legal_clears_err", longint'(cfg_err), 0);
        for (int i = 0; i < 8; i++) send(0);
        idle(8);

        // cfg_we coincident with in_valid drops the sample (accepted and rejected cases)
        step(1'b1, 500, 1'b1, 2, 4, 0, 0);
        for (int i = 0; i < 8; i++) send(0);
        idle(8);
        step(1'b1, 500, 1'b1, 0, 4, 0, 0);
        check_val("reject_with_valid", longint'(cfg_err), 1);
        for (int i = 0; i < 8; i++) send(0);
        idle(8);

        // Reset mid-pulse
        cfg(2, 4, 0, 0);
        send(100);
        for (int i = 0; i < 3; i++) send(0);
        cfg(0, 0, 0, 0);
        send(0);
        send(0);
        reset = 1'b0;
        prune();
        model_reset();
        @(posedge clk);
        #1;
        check_val("midrst_out_valid", longint'(out_valid), 0);
        check_val("midrst_out_data", longint'(out_data), 0);
        check_val("midrst_cfg_err", longint'(cfg_err), 0);
        reset = 1'b1;
        impulse(100, 1);

        // Randomised streams with legal and occasional illegal configuration writes
        for (int blk = 0; blk < 3; blk++) begin
            int k, l;
            k = int'($urandom_range(1, 20));
            l = k + int'($urandom_range(0, 20));
            cfg(k, l, int'($urandom_range(0, 255)), int'($urandom_range(0, 31)));
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    step(1'b1, 7, 1'b1, 50, 20, 3, 1);
                end else if ($urandom_range(0, 9) < 7) begin
                    send(int'($urandom_range(0, 4000)) - 2000);
                end else begin
                    idle(1);
                end
            end
            idle(8);
        end

        idle(10);
        check_val("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
